// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_pkg;

  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam logic [7:0] WAIT_LIMIT = 8'd255;
  localparam int         CNT_W      = 16;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic mem_wb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN = '{
    pc_write:      1'b1,
    if_id_write:   1'b1,
    id_ex_write:   1'b1,
    ex_mem_write:  1'b1,
    if_id_flush:   1'b0,
    id_ex_bubble:  1'b0,
    mem_wb_bubble: 1'b0
  };

  // $0 is hardwired to zero, so it can never carry a dependency.
  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] d);
    return (r == d) && (d != REG_ZERO);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !(&count_q)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/freeze control for a 5-stage pipeline with ID-stage branch resolution.
// Control outputs are combinational; only the memory-wait watchdog and event counters hold state.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_uses_rs,
  input  logic             ID_uses_rt,
  input  logic             ID_is_branch,
  input  logic             ID_redirect,
  input  logic [4:0]       EX_dst,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic [4:0]       MEM_dst,
  input  logic             MEM_RegWrite,
  input  logic             MEM_MemRead,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             ID_EX_write,
  output logic             EX_MEM_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             MEM_WB_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic   freeze;
  logic   hazard;
  logic   ex_hit;
  logic   mem_hit;
  ctrl_t  ctrl;
  state_e state_q;
  logic [7:0] wait_q;
  logic [7:0] wait_d;
  logic   timeout_q;

  // MEM_RegWrite only matters to forwarding, which lives outside this block.
  logic unused_mem_regwrite;
  assign unused_mem_regwrite = MEM_RegWrite;

  assign freeze = mem_req & ~mem_ready;

  assign ex_hit  = (ID_uses_rs & reg_match(ID_rs, EX_dst)) |
                   (ID_uses_rt & reg_match(ID_rt, EX_dst));
  assign mem_hit = (ID_uses_rs & reg_match(ID_rs, MEM_dst)) |
                   (ID_uses_rt & reg_match(ID_rt, MEM_dst));

  // A branch compares in ID, so it also waits on an ALU result in EX and a load in MEM.
  assign hazard = (EX_MemRead & ex_hit) |
                  (ID_is_branch & EX_RegWrite & ex_hit) |
                  (ID_is_branch & MEM_MemRead & mem_hit);

  always_comb begin
    ctrl = CTRL_RUN;
    if (reset) begin
      ctrl = '0;
    end else if (freeze) begin
      ctrl.pc_write      = 1'b0;
      ctrl.if_id_write   = 1'b0;
      ctrl.id_ex_write   = 1'b0;
      ctrl.ex_mem_write  = 1'b0;
      ctrl.mem_wb_bubble = 1'b1;
    end else if (hazard) begin
      ctrl.pc_write      = 1'b0;
      ctrl.if_id_write   = 1'b0;
      ctrl.id_ex_bubble  = 1'b1;
    end else if (ID_redirect) begin
      ctrl.if_id_flush   = 1'b1;
    end
  end

  assign PC_write      = ctrl.pc_write;
  assign IF_ID_write   = ctrl.if_id_write;
  assign ID_EX_write   = ctrl.id_ex_write;
  assign EX_MEM_write  = ctrl.ex_mem_write;
  assign IF_ID_flush   = ctrl.if_id_flush;
  assign ID_EX_bubble  = ctrl.id_ex_bubble;
  assign MEM_WB_bubble = ctrl.mem_wb_bubble;

  assign wait_d = (wait_q == WAIT_LIMIT) ? wait_q : wait_q + 8'd1;

  // The first frozen cycle is spent in RUN, so the counter starts from 0 on entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (freeze) begin
            state_q <= MEM_WAIT;
            wait_q  <= '0;
          end
        end
        MEM_WAIT: begin
          if (!freeze) begin
            state_q <= RUN;
          end else begin
            wait_q <= wait_d;
            if (wait_d == WAIT_LIMIT) begin
              timeout_q <= 1'b1;
            end
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign mem_timeout = timeout_q;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hazard & ~freeze),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_freeze_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (freeze),
    .count (freeze_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ctrl.if_id_flush),
    .count (flush_cnt)
  );

endmodule
